// File: rtl/alu_issue_scheduler.sv
// Round-robin issue scheduler feeding one single-cycle ALU, with a registered execute
// stage, a 2-entry in-order completion buffer toward the CDB, and branch squash/clear.
package alu_issue_pkg;
    typedef struct packed {
        logic       valid;
        logic [1:0] opcode;
        logic [5:0] dest_reg;
        logic [7:0] src_a;
        logic [7:0] src_b;
    } ALU_PACKET;

    typedef struct packed {
        logic       valid;
        logic [5:0] completing_reg;
        logic [7:0] value;
    } CDB_REG_PACKET;
endpackage

module alu_issue_scheduler
    import alu_issue_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BMASK_W = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  ALU_PACKET [NUM_REQ-1:0]           req_packet,
    input  logic [NUM_REQ-1:0][BMASK_W-1:0]   req_bmask,
    output logic [NUM_REQ-1:0]                req_ready,
    output ALU_PACKET                         alu_packet_out,
    input  CDB_REG_PACKET                     alu_result_in,
    input  logic                              br_valid,
    input  logic [BMASK_W-1:0]                br_mask,
    input  logic                              br_mispredict,
    output logic                              cdb_valid,
    output CDB_REG_PACKET                     cdb_packet,
    output logic [BMASK_W-1:0]                cdb_bmask,
    input  logic                              cdb_grant,
    output logic [1:0]                        buf_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic squash_hit(input logic [BMASK_W-1:0] m);
        return br_valid & br_mispredict & (|(m & br_mask));
    endfunction

    function automatic logic [BMASK_W-1:0] bmask_clear(input logic [BMASK_W-1:0] m);
        logic [BMASK_W-1:0] r;
        if (br_valid & ~br_mispredict) r = m & ~br_mask;
        else                           r = m;
        return r;
    endfunction

    // The valid field of each stored packet doubles as that slot's occupancy bit.
    ALU_PACKET                        ex_pkt_r, ex_nxt_s;
    logic [BMASK_W-1:0]               ex_bmask_r, ex_bm_nxt_s;
    CDB_REG_PACKET [1:0]              buf_pkt_r, buf_nxt_s;
    logic [1:0][BMASK_W-1:0]          buf_bmask_r, buf_bm_nxt_s;
    logic [PTR_W-1:0]                 rr_ptr_r, rr_nxt_s;

    logic [1:0]       buf_sq_s, keep_s;
    logic             deq_s, live_full_s, ex_sq_s, ex_moves_s, ex_free_s;
    logic             grant_found_s, grant_s;
    logic [PTR_W-1:0] grant_idx_s, idx_s;
    CDB_REG_PACKET    enq_pkt_s;
    logic             unused_valid_s;

    // Incoming valid fields are implied by the handshake and the ex-stage state.
    assign unused_valid_s = alu_result_in.valid ^ (^req_packet);

    // Squash, dequeue and ex-stage movement decisions for this cycle.
    always_comb begin
        buf_sq_s[0] = buf_pkt_r[0].valid & squash_hit(buf_bmask_r[0]);
        buf_sq_s[1] = buf_pkt_r[1].valid & squash_hit(buf_bmask_r[1]);
        cdb_valid   = buf_pkt_r[0].valid & ~buf_sq_s[0];
        deq_s       = cdb_valid & cdb_grant;
        keep_s[0]   = buf_pkt_r[0].valid & ~buf_sq_s[0] & ~deq_s;
        keep_s[1]   = buf_pkt_r[1].valid & ~buf_sq_s[1];
        live_full_s = (buf_pkt_r[0].valid & ~buf_sq_s[0]) & keep_s[1];
        ex_sq_s     = ex_pkt_r.valid & squash_hit(ex_bmask_r);
        ex_moves_s  = ex_pkt_r.valid & ~ex_sq_s & (~live_full_s | deq_s);
        ex_free_s   = ~ex_pkt_r.valid | ex_moves_s | ex_sq_s;
    end

    // Round-robin search from rr_ptr over lanes not hit by a squash.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        idx_s         = '0;
        req_ready     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!grant_found_s && req_valid[idx_s] && !squash_hit(req_bmask[idx_s])) begin
                grant_found_s = 1'b1;
                grant_idx_s   = idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_s = grant_found_s & ex_free_s;
        if (grant_s) begin
            req_ready[grant_idx_s] = 1'b1;
            rr_nxt_s = PTR_W'((int'(grant_idx_s) + 1) % NUM_REQ);
        end else begin
            rr_nxt_s = rr_ptr_r;
        end
    end

    // Execute-stage next state: load on grant, empty on move/squash, else hold.
    always_comb begin
        ex_nxt_s    = ex_pkt_r;
        ex_bm_nxt_s = bmask_clear(ex_bmask_r);
        if (grant_s) begin
            ex_nxt_s       = req_packet[grant_idx_s];
            ex_nxt_s.valid = 1'b1;
            ex_bm_nxt_s    = bmask_clear(req_bmask[grant_idx_s]);
        end else if (ex_moves_s | ex_sq_s) begin
            ex_nxt_s.valid = 1'b0;
        end else begin
            ex_nxt_s.valid = ex_pkt_r.valid;
        end
    end

    // Buffer next state: survivors compact toward the head, the ex result joins at the tail.
    always_comb begin
        enq_pkt_s          = alu_result_in;
        enq_pkt_s.valid    = 1'b1;
        buf_nxt_s          = buf_pkt_r;
        buf_nxt_s[0].valid = 1'b0;
        buf_nxt_s[1].valid = 1'b0;
        buf_bm_nxt_s[0]    = bmask_clear(buf_bmask_r[0]);
        buf_bm_nxt_s[1]    = bmask_clear(buf_bmask_r[1]);
        case (keep_s)
            2'b11: begin
                buf_nxt_s = buf_pkt_r;
            end
            2'b01: begin
                buf_nxt_s[0] = buf_pkt_r[0];
                if (ex_moves_s) begin
                    buf_nxt_s[1]    = enq_pkt_s;
                    buf_bm_nxt_s[1] = bmask_clear(ex_bmask_r);
                end else begin
                    buf_nxt_s[1].valid = 1'b0;
                end
            end
            2'b10: begin
                buf_nxt_s[0]    = buf_pkt_r[1];
                buf_bm_nxt_s[0] = bmask_clear(buf_bmask_r[1]);
                if (ex_moves_s) begin
                    buf_nxt_s[1]    = enq_pkt_s;
                    buf_bm_nxt_s[1] = bmask_clear(ex_bmask_r);
                end else begin
                    buf_nxt_s[1].valid = 1'b0;
                end
            end
            default: begin
                if (ex_moves_s) begin
                    buf_nxt_s[0]    = enq_pkt_s;
                    buf_bm_nxt_s[0] = bmask_clear(ex_bmask_r);
                end else begin
                    buf_nxt_s[0].valid = 1'b0;
                end
            end
        endcase
    end

    // State registers; reset drops all in-flight work at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_pkt_r    <= '0;
            ex_bmask_r  <= '0;
            buf_pkt_r   <= '0;
            buf_bmask_r <= '0;
            rr_ptr_r    <= '0;
        end else begin
            ex_pkt_r    <= ex_nxt_s;
            ex_bmask_r  <= ex_bm_nxt_s;
            buf_pkt_r   <= buf_nxt_s;
            buf_bmask_r <= buf_bm_nxt_s;
            rr_ptr_r    <= rr_nxt_s;
        end
    end

    // Output views of the stored state.
    always_comb begin
        alu_packet_out   = ex_pkt_r;
        cdb_packet       = buf_pkt_r[0];
        cdb_packet.valid = cdb_valid;
        cdb_bmask        = bmask_clear(buf_bmask_r[0]);
        buf_count        = {1'b0, buf_pkt_r[0].valid} + {1'b0, buf_pkt_r[1].valid};
    end
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: round-robin, backpressure, squash,
// correct-prediction mask clearing and asynchronous reset.
module tb_alu_issue_scheduler;
    import alu_issue_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [3:0]              req_valid;
    ALU_PACKET [3:0]         req_packet;
    logic [3:0][3:0]         req_bmask;
    logic [3:0]              req_ready;
    ALU_PACKET               alu_packet_out;
    CDB_REG_PACKET           alu_result_in;
    logic                    br_valid;
    logic [3:0]              br_mask;
    logic                    br_mispredict;
    logic                    cdb_valid;
    CDB_REG_PACKET           cdb_packet;
    logic [3:0]              cdb_bmask;
    logic                    cdb_grant;
    logic [1:0]              buf_count;

    int vectors = 0;
    int miscompares = 0;

    alu_issue_scheduler #(.NUM_REQ(4), .BMASK_W(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_packet(req_packet), .req_bmask(req_bmask),
        .req_ready(req_ready), .alu_packet_out(alu_packet_out), .alu_result_in(alu_result_in),
        .br_valid(br_valid), .br_mask(br_mask), .br_mispredict(br_mispredict),
        .cdb_valid(cdb_valid), .cdb_packet(cdb_packet), .cdb_bmask(cdb_bmask),
        .cdb_grant(cdb_grant), .buf_count(buf_count)
    );

    always #5 clock = ~clock;

    // Stand-in single-cycle ALU: opcode 0 adds, anything else subtracts.
    always_comb begin
        alu_result_in.valid          = alu_packet_out.valid;
        alu_result_in.completing_reg = alu_packet_out.dest_reg;
        alu_result_in.value          = (alu_packet_out.opcode == 2'd0)
                                       ? alu_packet_out.src_a + alu_packet_out.src_b
                                       : alu_packet_out.src_a - alu_packet_out.src_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int i, input logic [5:0] d, input logic [3:0] bm);
        req_packet[i].dest_reg = d;
        req_bmask[i] = bm;
    endtask

    task automatic step;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; req_valid = 4'h0; req_packet = '0; req_bmask = '0;
        br_valid = 1'b0; br_mask = 4'h0; br_mispredict = 1'b0; cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_packet[i].dest_reg = 6'(8 + i);
            req_packet[i].src_a    = 8'(16 * i + 1);
            req_packet[i].src_b    = 8'd3;
        end
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("rst_buf_count", 32'(buf_count), 32'h0);
        chk("rst_alu_valid", 32'(alu_packet_out.valid), 32'h0);

        // Round-robin with the CDB always granting.
        step; reset = 1'b1; cdb_grant = 1'b1; req_valid = 4'hF; #1;
        chk("rr_c0_ready", 32'(req_ready), 32'h1);
        chk("rr_c0_cdb", 32'(cdb_valid), 32'h0);
        step; #1;
        chk("rr_c1_ready", 32'(req_ready), 32'h2);
        chk("rr_c1_alu_valid", 32'(alu_packet_out.valid), 32'h1);
        chk("rr_c1_alu_dest", 32'(alu_packet_out.dest_reg), 32'd8);
        chk("rr_c1_no_bypass", 32'(cdb_valid), 32'h0);
        step; #1;
        chk("rr_c2_ready", 32'(req_ready), 32'h4);
        chk("rr_c2_cdb", 32'(cdb_valid), 32'h1);
        chk("rr_c2_reg", 32'(cdb_packet.completing_reg), 32'd8);
        chk("rr_c2_value", 32'(cdb_packet.value), 32'd4);
        chk("rr_c2_pkt_valid", 32'(cdb_packet.valid), 32'h1);
        step; #1;
        chk("rr_c3_ready", 32'(req_ready), 32'h8);
        chk("rr_c3_reg", 32'(cdb_packet.completing_reg), 32'd9);
        step; #1;
        chk("rr_c4_ready", 32'(req_ready), 32'h1);
        chk("rr_c4_reg", 32'(cdb_packet.completing_reg), 32'd10);
        step; req_valid = 4'h0; #1;
        chk("rr_c5_reg", 32'(cdb_packet.completing_reg), 32'd11);
        step; #1;
        chk("rr_c6_reg", 32'(cdb_packet.completing_reg), 32'd8);
        step; #1;
        chk("rr_c7_cdb", 32'(cdb_valid), 32'h0);
        chk("rr_c7_count", 32'(buf_count), 32'h0);

        // Backpressure: lane 2 streams with no CDB grant.
        step; cdb_grant = 1'b0; req_valid = 4'b0100; lane(2, 6'd20, 4'h0); #1;
        chk("bp_b0_ready", 32'(req_ready), 32'h4);
        step; lane(2, 6'd21, 4'h0); #1;
        chk("bp_b1_ready", 32'(req_ready), 32'h4);
        step; lane(2, 6'd22, 4'h0); #1;
        chk("bp_b2_ready", 32'(req_ready), 32'h4);
        step; lane(2, 6'd23, 4'h0); #1;
        chk("bp_b3_ready", 32'(req_ready), 32'h0);
        chk("bp_b3_count", 32'(buf_count), 32'h2);
        chk("bp_b3_reg", 32'(cdb_packet.completing_reg), 32'd20);
        step; #1;
        chk("bp_b4_ready", 32'(req_ready), 32'h0);
        step; cdb_grant = 1'b1; #1;
        chk("bp_b5_ready", 32'(req_ready), 32'h4);
        chk("bp_b5_cdb", 32'(cdb_valid), 32'h1);
        step; cdb_grant = 1'b0; req_valid = 4'h0; #1;
        chk("bp_b6_count", 32'(buf_count), 32'h2);
        chk("bp_b6_reg", 32'(cdb_packet.completing_reg), 32'd21);
        chk("bp_b6_alu_dest", 32'(alu_packet_out.dest_reg), 32'd23);
        step; cdb_grant = 1'b1;
        step; step; step; #1;
        chk("bp_drain_count", 32'(buf_count), 32'h0);
        chk("bp_drain_alu", 32'(alu_packet_out.valid), 32'h0);

        // Mispredict: ex 0010, buffer 0001/0010, lane 1 requests with 0010.
        cdb_grant = 1'b0; req_valid = 4'b1000; lane(3, 6'd30, 4'b0001); #1;
        chk("sq_s0_ready", 32'(req_ready), 32'h8);
        step; lane(3, 6'd31, 4'b0010); #1;
        chk("sq_s1_ready", 32'(req_ready), 32'h8);
        step; lane(3, 6'd32, 4'b0010); #1;
        chk("sq_s2_ready", 32'(req_ready), 32'h8);
        step; req_valid = 4'b0010; lane(1, 6'd33, 4'b0010);
        br_valid = 1'b1; br_mask = 4'b0010; br_mispredict = 1'b1; #1;
        chk("sq_s3_ready", 32'(req_ready), 32'h0);
        chk("sq_s3_cdb", 32'(cdb_valid), 32'h1);
        chk("sq_s3_count", 32'(buf_count), 32'h2);
        step; br_valid = 1'b0; req_valid = 4'h0; lane(1, 6'd33, 4'h0); #1;
        chk("sq_s4_count", 32'(buf_count), 32'h1);
        chk("sq_s4_alu", 32'(alu_packet_out.valid), 32'h0);
        chk("sq_s4_reg", 32'(cdb_packet.completing_reg), 32'd30);
        chk("sq_s4_bmask", 32'(cdb_bmask), 32'h1);
        step; cdb_grant = 1'b1;
        step; cdb_grant = 1'b0; #1;
        chk("sq_drain_count", 32'(buf_count), 32'h0);

        // Squashed head while the CDB grants.
        req_valid = 4'b0001; lane(0, 6'd34, 4'b0100); #1;
        chk("sh_t0_ready", 32'(req_ready), 32'h1);
        step; req_valid = 4'b0010; lane(1, 6'd35, 4'h0); #1;
        chk("sh_t1_ready", 32'(req_ready), 32'h2);
        step; req_valid = 4'h0;
        step; br_valid = 1'b1; br_mask = 4'b0100; br_mispredict = 1'b1; cdb_grant = 1'b1; #1;
        chk("sh_t3_cdb", 32'(cdb_valid), 32'h0);
        chk("sh_t3_count", 32'(buf_count), 32'h2);
        step; br_valid = 1'b0; cdb_grant = 1'b0; #1;
        chk("sh_t4_cdb", 32'(cdb_valid), 32'h1);
        chk("sh_t4_reg", 32'(cdb_packet.completing_reg), 32'd35);
        chk("sh_t4_count", 32'(buf_count), 32'h1);
        step; cdb_grant = 1'b1;
        step; cdb_grant = 1'b0;

        // Correct prediction clears bit 0100 everywhere.
        req_valid = 4'b0100; lane(2, 6'd40, 4'b0110); #1;
        chk("cp_u0_ready", 32'(req_ready), 32'h4);
        step; req_valid = 4'b1000; lane(3, 6'd41, 4'b0100); #1;
        chk("cp_u1_ready", 32'(req_ready), 32'h8);
        step; req_valid = 4'b0001; lane(0, 6'd42, 4'b1100); #1;
        chk("cp_u2_ready", 32'(req_ready), 32'h1);
        step; req_valid = 4'h0; br_valid = 1'b1; br_mask = 4'b0100; br_mispredict = 1'b0; #1;
        chk("cp_u3_bmask", 32'(cdb_bmask), 32'h2);
        chk("cp_u3_count", 32'(buf_count), 32'h2);
        chk("cp_u3_cdb", 32'(cdb_valid), 32'h1);
        step; br_valid = 1'b0; #1;
        chk("cp_u4_bmask", 32'(cdb_bmask), 32'h2);
        chk("cp_u4_count", 32'(buf_count), 32'h2);
        chk("cp_u4_alu_dest", 32'(alu_packet_out.dest_reg), 32'd42);
        cdb_grant = 1'b1;
        step; #1;
        chk("cp_u5_reg", 32'(cdb_packet.completing_reg), 32'd41);
        chk("cp_u5_bmask", 32'(cdb_bmask), 32'h0);
        step; cdb_grant = 1'b0; #1;
        chk("cp_u6_reg", 32'(cdb_packet.completing_reg), 32'd42);
        chk("cp_u6_bmask", 32'(cdb_bmask), 32'h8);
        chk("cp_u6_count", 32'(buf_count), 32'h1);

        // Asynchronous reset with a full pipeline.
        step; req_valid = 4'b0010; lane(1, 6'd43, 4'h0); #1;
        chk("ar_u7_ready", 32'(req_ready), 32'h2);
        step; req_valid = 4'b0100; lane(2, 6'd44, 4'h0); #1;
        chk("ar_u8_ready", 32'(req_ready), 32'h4);
        step; req_valid = 4'h0; #1;
        chk("ar_pre_count", 32'(buf_count), 32'h2);
        chk("ar_pre_alu", 32'(alu_packet_out.valid), 32'h1);
        reset = 1'b0; #1;
        chk("ar_cdb", 32'(cdb_valid), 32'h0);
        chk("ar_count", 32'(buf_count), 32'h0);
        chk("ar_alu", 32'(alu_packet_out.valid), 32'h0);
        chk("ar_ready", 32'(req_ready), 32'h0);
        chk("ar_bmask", 32'(cdb_bmask), 32'h0);
        step; reset = 1'b1; req_valid = 4'hF; #1;
        chk("ar_rr_restart", 32'(req_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

Round-robin issue scheduler that shares one single-cycle `alu` among `NUM_REQ` reservation-station issue lanes. It registers the granted `ALU_PACKET` into an execute stage that drives the ALU, and captures the `CDB_REG_PACKET` result into a 2-entry completion buffer. The buffer requests the CDB and holds each result until granted. In-flight work is squashed or has its branch mask updated on branch resolution.

## Interface
- `NUM_REQ`, default 4: number of issue lanes (≥2).
- `BMASK_W`, default 4: branch-mask width (one bit per unresolved branch).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: lane i has a ready ALU instruction.
- `req_packet` in `NUM_REQ` x `ALU_PACKET`: per-lane instruction.
- `req_bmask` in `NUM_REQ` x `BMASK_W`: per-lane branch mask.
- `req_ready` out `NUM_REQ`: one-hot-or-zero grant; lane i transfers when `req_valid[i] & req_ready[i]`.
- `alu_packet_out` out `ALU_PACKET`: execute-stage register to the `alu`. Its `valid` field equals `ex_valid`.
- `alu_result_in` in `CDB_REG_PACKET`: combinational `alu` result for `alu_packet_out`.
- `br_valid` in 1: branch resolved this cycle.
- `br_mask` in `BMASK_W`: one-hot bit of the resolving branch.
- `br_mispredict` in 1: qualifies `br_valid`. 1 means squash; 0 means clear the bit.
- `cdb_valid` out 1: buffer head requests the CDB.
- `cdb_packet` out `CDB_REG_PACKET`: buffer head. Its `valid` field equals `cdb_valid`.
- `cdb_bmask` out `BMASK_W`: branch mask of the head.
- `cdb_grant` in 1: CDB accepts the head this cycle. Ignored when `cdb_valid`=0.
- `buf_count` out 2: completion-buffer occupancy, 0..2.

## Operation
- **State:** execute stage (`ex_valid`, packet, bmask), completion buffer of 2 entries (valid, packet, bmask, in order), and `rr_ptr` (log2 `NUM_REQ` bits).
- **Squash hit:** `squash_hit(m)` = `br_valid & br_mispredict & |(m & br_mask)`.
- **Arbitration:**
  - Eligible lanes: `req_valid[i] & ~squash_hit(req_bmask[i])`.
  - Priority: search from `rr_ptr` upward, wrapping modulo `NUM_REQ`. The first eligible lane gets `req_ready` only if `ex_free`.
  - After a grant to lane g, `rr_ptr` becomes (g+1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
- **Execute stage:**
  - `ex_moves` = `ex_valid` & not squashed & (`buf_count` < 2 after squash, or head dequeue this cycle).
  - `ex_free` = `~ex_valid` | `ex_moves` | ex squashed.
  - An ex entry that is neither moving nor squashed holds its state.
- **Buffer:**
  - Enqueue `alu_result_in` plus the ex bmask at the tail on `ex_moves`.
  - Dequeue the head on `cdb_valid & cdb_grant`.
  - Squashed entries are removed on the same edge. Survivors stay in order and compact toward the head.
- **CDB output:** `cdb_valid` = head valid & ~`squash_hit(head bmask)`. This combinational mask prevents a squashed result from winning the CDB.
- **Correct prediction** (`br_valid & ~br_mispredict`): clear the `br_mask` bit in the stored bmask of ex and both buffer entries. The ex→buffer transfer carries the cleared mask. `cdb_bmask` shows the cleared value combinationally in the same cycle.
- **Simultaneous events:** a squash, a grant, a move and a dequeue can all occur in one cycle. Occupancy must never exceed 2 or go negative.

## Timing
- **Reset values:** `ex_valid`=0, all buffer valids=0, `rr_ptr`=0. Therefore `req_ready`=0, `cdb_valid`=0, `buf_count`=0, `alu_packet_out.valid`=0.
  - Reset asserted mid-operation discards all in-flight work immediately (asynchronously).
- **Latency:**
  - Lane accepted at cycle t → `alu_packet_out` valid at t+1.
  - Result enters the buffer at t+2, so `cdb_valid`=1 no earlier than t+2.
  - Zero-cycle bypass from a request to the CDB is forbidden.
- **Throughput:** one issue per cycle while `cdb_grant` is held high.
- **Backpressure:** with `cdb_grant` held low, at most 3 instructions are in flight (buffer 2 + ex 1), after which `req_ready`=0.
  - The first `cdb_grant` frees a slot. `req_ready` may then rise combinationally in that same cycle.
- `req_ready` depends combinationally on `req_valid`, `req_bmask`, branch inputs, `cdb_grant` and state. There is no path from `req_*` to `cdb_*`.

## Test plan
- **Reset then round-robin:** all 4 lanes valid every cycle, `cdb_grant`=1 → grants go to lanes 0,1,2,3,0. The `cdb_packet.completing_reg` sequence matches, first appearing 2 cycles after the first grant.
- **Backpressure:** one lane streaming, `cdb_grant`=0 → exactly 3 accepts, then `req_ready`=0, `buf_count`=2. Raising `cdb_grant` for 1 cycle → 1 dequeue and 1 new accept in that cycle.
- **Mispredict squash:** ex bmask 0010, buffer masks 0001 and 0010, `br_mask`=0010, `br_mispredict`=1 → ex and buffer entry 1 are dropped, entry 0 survives, `buf_count`=1. A request with bmask 0010 in the same cycle gets no grant.
- **Squashed head with grant:** head bmask 0100 and `cdb_grant`=1 in the mispredict cycle for 0100 → `cdb_valid`=0 that cycle and no double-pop. The next entry becomes the head.
- **Correct prediction:** entries carrying bit 0100, `br_mispredict`=0 → all stored masks and `cdb_bmask` drop bit 0100, and no entries are lost.
- **Async reset mid-stream:** assert `reset`=0 with `buf_count`=2 and ex valid → all outputs are 0 before the next clock edge, and `rr_ptr` restarts at lane 0.
